// File: rtl/isp1761_bus_ctrl.sv
// isp1761_bus_ctrl: Avalon-MM slave to timed ISP1761 external-bus bridge.
// Ports: clk/reset_n; Avalon slave s_* (chipselect, address, read, write,
//   writedata, readdata, waitrequest, irq); ISP1761 pins CS_N, RD_N, WR_N,
//   A[ADDR_W-1:1], bidirectional D, raw IRQ_IN levels.
module isp1761_bus_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 18,
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 3,
    parameter int HOLD_CYC    = 1,
    parameter int TURN_CYC    = 2,
    parameter int IRQ_CH      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_chipselect,
    input  logic [ADDR_W-1:0] s_address,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [DATA_W-1:0] s_writedata,
    output logic [DATA_W-1:0] s_readdata,
    output logic              s_waitrequest,
    output logic [IRQ_CH-1:0] s_irq,
    output logic              CS_N,
    output logic              RD_N,
    output logic              WR_N,
    output logic [ADDR_W-2:0] A,
    inout  wire  [DATA_W-1:0] D,
    input  logic [IRQ_CH-1:0] IRQ_IN
);

    if (SETUP_CYC < 0 || SETUP_CYC > 15 ||
        STROBE_CYC < 1 || STROBE_CYC > 15 ||
        HOLD_CYC < 1 || HOLD_CYC > 15 ||
        TURN_CYC < 0 || TURN_CYC > 15 ||
        IRQ_CH < 1 || SYNC_STAGES < 2 ||
        DATA_W < 1 || ADDR_W < 2) begin : g_bad_param
        $error("isp1761_bus_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        TURN
    } state_t;

    // Counter reload values: each state lasts (load + 1) cycles.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] TURN_LD   = 4'(TURN_CYC - 1);

    state_t              state;
    state_t              state_nx;
    logic [3:0]          cnt;
    logic [3:0]          cnt_nx;
    logic                accept;
    logic                dir_wr;
    logic                dir_nx;
    logic [ADDR_W-2:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                cs_n_q;
    logic                rd_n_q;
    logic                wr_n_q;
    logic                oe_q;
    logic                wait_q;
    logic                active_nx;
    logic                capture;
    logic [IRQ_CH-1:0]   sync_q [SYNC_STAGES];
    logic                unused_addr0;

    assign unused_addr0 = s_address[0];

    assign accept = (state == IDLE) && s_chipselect && (s_read || s_write);
    // A simultaneous read and write is treated as a write.
    assign dir_nx = accept ? s_write : dir_wr;

    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (SETUP_CYC == 0) begin
                        state_nx = STROBE;
                        cnt_nx   = STROBE_LD;
                    end else begin
                        state_nx = SETUP;
                        cnt_nx   = SETUP_LD;
                    end
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_nx = STROBE;
                    cnt_nx   = STROBE_LD;
                end
            end
            STROBE: begin
                if (cnt == 4'd0) begin
                    state_nx = HOLD;
                    cnt_nx   = HOLD_LD;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    if (!dir_wr && TURN_CYC > 0) begin
                        state_nx = TURN;
                        cnt_nx   = TURN_LD;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = 4'd0;
                    end
                end
            end
            TURN: begin
                if (cnt == 4'd0) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    assign active_nx = (state_nx == SETUP) || (state_nx == STROBE) ||
                       (state_nx == HOLD);

    // Sample the bus at the end of the final strobe cycle of a read.
    assign capture = (state == STROBE) && (cnt == 4'd0) && !dir_wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            dir_wr  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            wait_q  <= 1'b1;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            dir_wr <= dir_nx;
            if (accept) begin
                addr_q  <= s_address[ADDR_W-1:1];
                wdata_q <= s_writedata;
            end
            if (capture) begin
                rdata_q <= D;
            end
            // Pin registers are loaded from the next state so that every
            // pin changes exactly on the edge that enters the new state.
            cs_n_q <= !active_nx;
            rd_n_q <= !((state_nx == STROBE) && !dir_nx);
            wr_n_q <= !((state_nx == STROBE) && dir_nx);
            oe_q   <= active_nx && dir_nx;
            wait_q <= !((state_nx == HOLD) && (cnt_nx == 4'd0));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= IRQ_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign D             = oe_q ? wdata_q : {DATA_W{1'bz}};
    assign CS_N          = cs_n_q;
    assign RD_N          = rd_n_q;
    assign WR_N          = wr_n_q;
    assign A             = addr_q;
    assign s_readdata    = rdata_q;
    assign s_waitrequest = wait_q;
    assign s_irq         = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_isp1761_bus_ctrl.sv
// tb_isp1761_bus_ctrl: bench for isp1761_bus_ctrl, default and fast timing.
// Ports: none; drives two DUT instances and models the external ISP1761.
`timescale 1ns/1ps
module tb_isp1761_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cs = 2'b00;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [17:0] addr = '0;
    logic [31:0] wdat = '0;
    logic [1:0]  irq_in = 2'b00;
    logic [31:0] ext_val = 32'hDEAD_BEEF;

    logic [31:0] rdata_w [2];
    logic [16:0] a_w [2];
    logic [1:0]  sirq_w [2];
    wire  [1:0]  wait_w;
    wire  [1:0]  csn_w;
    wire  [1:0]  rdn_w;
    wire  [1:0]  wrn_w;
    wire  [31:0] d0;
    wire  [31:0] d1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External device: drives the bus only while its read strobe is low.
    assign d0 = rdn_w[0] ? 32'bz : ext_val;
    assign d1 = rdn_w[1] ? 32'bz : ext_val;
    for (genvar i = 0; i < 32; i++) begin : g_pd
        pulldown (d0[i]);
        pulldown (d1[i]);
    end

    isp1761_bus_ctrl u_dut0 (
        .clk(clk), .reset_n(rst_n), .s_chipselect(cs[0]),
        .s_address(addr), .s_read(rd), .s_write(wr),
        .s_writedata(wdat), .s_readdata(rdata_w[0]),
        .s_waitrequest(wait_w[0]), .s_irq(sirq_w[0]),
        .CS_N(csn_w[0]), .RD_N(rdn_w[0]), .WR_N(wrn_w[0]),
        .A(a_w[0]), .D(d0), .IRQ_IN(irq_in)
    );

    isp1761_bus_ctrl #(
        .SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(1)
    ) u_dut1 (
        .clk(clk), .reset_n(rst_n), .s_chipselect(cs[1]),
        .s_address(addr), .s_read(rd), .s_write(wr),
        .s_writedata(wdat), .s_readdata(rdata_w[1]),
        .s_waitrequest(wait_w[1]), .s_irq(sirq_w[1]),
        .CS_N(csn_w[1]), .RD_N(rdn_w[1]), .WR_N(wrn_w[1]),
        .A(a_w[1]), .D(d1), .IRQ_IN(irq_in)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: ph = cycle number within a transfer (accept cycle is 1,
    // completion is L = 1+S+T+H); tl = remaining turnaround cycles.
    int PS [2] = '{1, 0};
    int PT [2] = '{3, 1};
    int PH [2] = '{1, 1};
    int PU [2] = '{2, 2};
    int ph [2] = '{0, 0};
    int tl [2] = '{0, 0};
    logic        mw [2];
    logic [16:0] ma [2];
    logic [31:0] mwd [2];
    logic [31:0] mrd [2] = '{32'h0, 32'h0};
    logic [1:0]  ih1 = 2'b00;
    logic [1:0]  ih2 = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                ph[d]  = 0;
                tl[d]  = 0;
                mrd[d] = 32'h0;
            end
            ih1 = 2'b00;
            ih2 = 2'b00;
        end else begin
            for (int d = 0; d < 2; d++) begin
                int len;
                len = 1 + PS[d] + PT[d] + PH[d];
                if (ph[d] == 0 && tl[d] == 0) begin
                    if (cs[d] && (rd || wr)) begin
                        ph[d]  = 2;
                        mw[d]  = wr;
                        ma[d]  = addr[17:1];
                        mwd[d] = wdat;
                    end
                end else if (tl[d] > 0) begin
                    tl[d]--;
                end else begin
                    if (!mw[d] && ph[d] == len - PH[d]) mrd[d] = ext_val;
                    if (ph[d] == len) begin
                        ph[d] = 0;
                        if (!mw[d]) tl[d] = PU[d];
                    end else begin
                        ph[d]++;
                    end
                end
            end
            ih2 = ih1;
            ih1 = irq_in;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int len;
            logic act;
            logic strb;
            logic [31:0] ed;
            logic [31:0] dv;
            len  = 1 + PS[d] + PT[d] + PH[d];
            act  = ph[d] >= 2 && ph[d] <= len;
            strb = ph[d] >= PS[d] + 2 && ph[d] <= len - PH[d];
            dv   = (d == 0) ? d0 : d1;
            if (act && mw[d]) ed = mwd[d];
            else if (strb && !mw[d]) ed = ext_val;
            else ed = 32'h0;
            chk($sformatf("cs_n%0d", d), 32'(csn_w[d]), 32'(!act));
            chk($sformatf("rd_n%0d", d), 32'(rdn_w[d]),
                32'(!(strb && !mw[d])));
            chk($sformatf("wr_n%0d", d), 32'(wrn_w[d]),
                32'(!(strb && mw[d])));
            chk($sformatf("wait%0d", d), 32'(wait_w[d]),
                32'(ph[d] != len));
            chk($sformatf("d%0d", d), dv, ed);
            chk($sformatf("rdata%0d", d), rdata_w[d], mrd[d]);
            chk($sformatf("irq%0d", d), 32'(sirq_w[d]), 32'(ih2));
            if (act) chk($sformatf("a%0d", d), 32'(a_w[d]), 32'(ma[d]));
        end
    end

    // Holds the request until waitrequest is seen low; entered and left
    // at 1 ns after a rising edge. cyc counts cycles up to completion.
    task automatic access(input int d, input logic r, input logic w,
                          input logic [17:0] ad, input logic [31:0] dat,
                          output int cyc, output logic [16:0] adone);
        bit done;
        cs[d] = 1'b1;
        rd    = r;
        wr    = w;
        addr  = ad;
        wdat  = dat;
        cyc   = 0;
        done  = 0;
        adone = '0;
        for (int n = 0; n < 60 && !done; n++) begin
            @(negedge clk);
            cyc++;
            if (wait_w[d] == 1'b0) begin
                done  = 1;
                adone = a_w[d];
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL timeout dut%0d: got no completion required one", d);
        end
        @(posedge clk);
        #1;
        cs = 2'b00;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [16:0] ad;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(csn_w[0]), 32'h1);
        chk("rst_wait", 32'(wait_w[0]), 32'h1);
        chk("rst_rdata", rdata_w[0], 32'h0);
        chk("rst_d", d0, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        access(0, 1'b0, 1'b1, 18'h00304, 32'hA5A5_1234, cyc, ad);
        chk("wr_latency", 32'(cyc), 32'd6);
        chk("wr_addr", 32'(ad), 32'h00182);

        wdat = 32'h5555_AAAA;
        access(0, 1'b1, 1'b0, 18'h00100, 32'h5555_AAAA, cyc, ad);
        chk("rd_latency", 32'(cyc), 32'd6);
        chk("rd_data", rdata_w[0], 32'hDEAD_BEEF);

        ext_val = 32'h1234_5678;
        access(0, 1'b1, 1'b0, 18'h00200, 32'h0F0F_0F0F, cyc, ad);
        access(0, 1'b0, 1'b1, 18'h00204, 32'h0BAD_F00D, cyc, ad);
        chk("turn_latency", 32'(cyc), 32'd8);
        chk("rd2_data", rdata_w[0], 32'h1234_5678);

        access(0, 1'b1, 1'b1, 18'h00010, 32'h0000_0001, cyc, ad);
        chk("rw_latency", 32'(cyc), 32'd6);
        chk("rw_rdata", rdata_w[0], 32'h1234_5678);

        cs[0] = 1'b1;
        wr    = 1'b1;
        addr  = 18'h00040;
        wdat  = 32'hCAFE_0001;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_wr_n", 32'(wrn_w[0]), 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_cs_n", 32'(csn_w[0]), 32'h1);
        chk("arst_wr_n", 32'(wrn_w[0]), 32'h1);
        chk("arst_d", d0, 32'h0);
        chk("arst_rdata", rdata_w[0], 32'h0);
        cs[0] = 1'b0;
        wr    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(0, 1'b0, 1'b1, 18'h00044, 32'h1357_9BDF, cyc, ad);
        chk("post_rst_latency", 32'(cyc), 32'd6);

        irq_in = 2'b10;
        @(posedge clk);
        #1;
        chk("irq_edge1", 32'(sirq_w[0]), 32'h0);
        @(posedge clk);
        #1;
        chk("irq_edge2", 32'(sirq_w[0]), 32'h2);
        irq_in = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        chk("irq_ch0", 32'(sirq_w[1]), 32'h1);

        access(1, 1'b0, 1'b1, 18'h00088, 32'h0000_0077, cyc, ad);
        chk("fast_wr_latency", 32'(cyc), 32'd3);
        chk("fast_wr_addr", 32'(ad), 32'h00044);
        ext_val = 32'h8765_4321;
        access(1, 1'b1, 1'b0, 18'h0008C, 32'h0, cyc, ad);
        chk("fast_rd_latency", 32'(cyc), 32'd3);
        chk("fast_rd_data", rdata_w[1], 32'h8765_4321);

        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
